// File: rtl/vx_mem_rr_arbiter_if.sv
// Bundle of the requester-side and memory-side buses of vx_mem_rr_arbiter.
// slave = arbiter view, master = the surrounding requesters and memory.
interface vx_mem_rr_arbiter_if #(
  parameter int unsigned NUM_REQS     = 4,
  parameter int unsigned ADDR_WIDTH   = 26,
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned TAG_IN_WIDTH = 8
);
  localparam int unsigned BYTEEN_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned SEL_BITS      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0;
  localparam int unsigned TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS;

  logic [NUM_REQS-1:0]              req_valid_in;
  logic [NUM_REQS-1:0]              req_rw_in;
  logic [NUM_REQS*BYTEEN_WIDTH-1:0] req_byteen_in;
  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in;
  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in;
  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in;
  logic [NUM_REQS-1:0]              req_ready_in;

  logic                     mem_req_valid;
  logic                     mem_req_rw;
  logic [BYTEEN_WIDTH-1:0]  mem_req_byteen;
  logic [ADDR_WIDTH-1:0]    mem_req_addr;
  logic [DATA_WIDTH-1:0]    mem_req_data;
  logic [TAG_OUT_WIDTH-1:0] mem_req_tag;
  logic                     mem_req_ready;

  logic                     mem_rsp_valid;
  logic [DATA_WIDTH-1:0]    mem_rsp_data;
  logic [TAG_OUT_WIDTH-1:0] mem_rsp_tag;
  logic                     mem_rsp_ready;

  logic [NUM_REQS-1:0]      rsp_valid_out;
  logic [DATA_WIDTH-1:0]    rsp_data_out;
  logic [TAG_IN_WIDTH-1:0]  rsp_tag_out;
  logic [NUM_REQS-1:0]      rsp_ready_out;

  logic                     busy;

  modport slave (
    input  req_valid_in, req_rw_in, req_byteen_in, req_addr_in, req_data_in, req_tag_in,
    output req_ready_in,
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready,
    output rsp_valid_out, rsp_data_out, rsp_tag_out,
    input  rsp_ready_out,
    output busy
  );

  modport master (
    output req_valid_in, req_rw_in, req_byteen_in, req_addr_in, req_data_in, req_tag_in,
    input  req_ready_in,
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready,
    input  rsp_valid_out, rsp_data_out, rsp_tag_out,
    output rsp_ready_out,
    input  busy
  );
endinterface

// File: rtl/vx_mem_rr_arbiter.sv
// Round-robin merge of NUM_REQS memory request ports into one registered stage,
// tag-routed responses, and per-requester outstanding-read throttling.
module vx_mem_rr_arbiter #(
  parameter int unsigned NUM_REQS     = 4,
  parameter int unsigned ADDR_WIDTH   = 26,
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned TAG_IN_WIDTH = 8,
  parameter int unsigned MAX_PENDING  = 16
) (
  input logic                clk,
  input logic                reset,
  vx_mem_rr_arbiter_if.slave bus
);
  localparam int unsigned BYTEEN_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned SEL_BITS      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0;
  localparam int unsigned SEL_W         = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int unsigned TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS;
  localparam int unsigned CNT_W         = $clog2(MAX_PENDING + 1);

  logic [CNT_W-1:0] pending   [NUM_REQS];
  logic [CNT_W-1:0] pending_n [NUM_REQS];
  logic [SEL_W-1:0] ptr, ptr_n, win, win_hi, win_lo, rsp_idx;
  logic [NUM_REQS-1:0] eligible, inc_vec, dec_vec, rsp_valid_vec;
  logic has_win, has_hi, has_lo, stage_en, fire, read_fire, valid_n;
  logic rsp_ready_sel, rsp_fire, idx_ok, any_pending_n, dec_at_zero;

  logic                     sel_rw;
  logic [BYTEEN_WIDTH-1:0]  sel_byteen;
  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [TAG_IN_WIDTH-1:0]  sel_tag_in;
  logic [TAG_OUT_WIDTH-1:0] sel_tag;

  logic                     valid_r, rw_r, busy_r;
  logic [BYTEEN_WIDTH-1:0]  byteen_r;
  logic [ADDR_WIDTH-1:0]    addr_r;
  logic [DATA_WIDTH-1:0]    data_r;
  logic [TAG_OUT_WIDTH-1:0] tag_r;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++)
      eligible[i] = bus.req_valid_in[i] &&
                    (bus.req_rw_in[i] || (pending[i] < CNT_W'(MAX_PENDING)));
  end

  // Wrapping scan as two passes: first eligible at/above ptr, else first below it.
  always_comb begin
    has_hi = 1'b0;
    has_lo = 1'b0;
    win_hi = '0;
    win_lo = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (eligible[i]) begin
        if (SEL_W'(i) >= ptr) begin
          if (!has_hi) begin
            has_hi = 1'b1;
            win_hi = SEL_W'(i);
          end
        end else if (!has_lo) begin
          has_lo = 1'b1;
          win_lo = SEL_W'(i);
        end
      end
    end
    has_win = has_hi || has_lo;
    win     = has_hi ? win_hi : win_lo;
  end

  assign stage_en  = !valid_r || bus.mem_req_ready;
  assign fire      = stage_en && has_win;
  assign read_fire = fire && !sel_rw;
  assign valid_n   = stage_en ? has_win : valid_r;
  assign ptr_n     = (win == SEL_W'(NUM_REQS - 1)) ? '0 : win + SEL_W'(1);
  assign bus.req_ready_in = fire ? (NUM_REQS'(1) << win) : '0;

  always_comb begin
    sel_rw     = 1'b0;
    sel_byteen = '0;
    sel_addr   = '0;
    sel_data   = '0;
    sel_tag_in = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (win == SEL_W'(i)) begin
        sel_rw     = bus.req_rw_in[i];
        sel_byteen = bus.req_byteen_in[i*BYTEEN_WIDTH +: BYTEEN_WIDTH];
        sel_addr   = bus.req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data   = bus.req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tag_in = bus.req_tag_in[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
      end
    end
  end

  generate
    if (SEL_BITS > 0) begin : g_idx
      assign sel_tag = {win, sel_tag_in};
      assign rsp_idx = bus.mem_rsp_tag[TAG_OUT_WIDTH-1 -: SEL_W];
    end else begin : g_noidx
      assign sel_tag = sel_tag_in;
      assign rsp_idx = '0;
    end
  endgenerate

  // An index with no matching requester leaves ready at 1 so the response drains.
  always_comb begin
    rsp_ready_sel = 1'b1;
    rsp_valid_vec = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (rsp_idx == SEL_W'(i)) begin
        rsp_ready_sel    = bus.rsp_ready_out[i];
        rsp_valid_vec[i] = bus.mem_rsp_valid;
      end
    end
  end

  assign idx_ok            = ({1'b0, rsp_idx} < (SEL_W + 1)'(NUM_REQS));
  assign rsp_fire          = bus.mem_rsp_valid && rsp_ready_sel;
  assign bus.mem_rsp_ready = rsp_ready_sel;
  assign bus.rsp_valid_out = rsp_valid_vec;
  assign bus.rsp_data_out  = bus.mem_rsp_data;
  assign bus.rsp_tag_out   = bus.mem_rsp_tag[TAG_IN_WIDTH-1:0];

  always_comb begin
    inc_vec       = '0;
    dec_vec       = '0;
    any_pending_n = 1'b0;
    dec_at_zero   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      pending_n[i] = pending[i];
      inc_vec[i]   = read_fire && (win == SEL_W'(i));
      dec_vec[i]   = rsp_fire && (rsp_idx == SEL_W'(i));
      if (inc_vec[i] && !dec_vec[i]) begin
        pending_n[i] = pending[i] + CNT_W'(1);
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (pending[i] == '0) dec_at_zero = 1'b1;
        else                  pending_n[i] = pending[i] - CNT_W'(1);
      end
      any_pending_n = any_pending_n || (pending_n[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      ptr     <= '0;
      for (int unsigned i = 0; i < NUM_REQS; i++) pending[i] <= '0;
    end else begin
      valid_r <= valid_n;
      busy_r  <= valid_n || any_pending_n;
      if (fire) begin
        rw_r     <= sel_rw;
        byteen_r <= sel_byteen;
        addr_r   <= sel_addr;
        data_r   <= sel_data;
        tag_r    <= sel_tag;
        ptr      <= ptr_n;
      end
      for (int unsigned i = 0; i < NUM_REQS; i++) pending[i] <= pending_n[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.mem_rsp_valid && !idx_ok)) else $error("response index out of range");
      assert (!dec_at_zero) else $error("response for requester with no pending reads");
    end
  end

  assign bus.mem_req_valid  = valid_r;
  assign bus.mem_req_rw     = rw_r;
  assign bus.mem_req_byteen = byteen_r;
  assign bus.mem_req_addr   = addr_r;
  assign bus.mem_req_data   = data_r;
  assign bus.mem_req_tag    = tag_r;
  assign bus.busy           = busy_r;
endmodule

// File: tb/tb_vx_mem_rr_arbiter.sv
// Randomized and directed bench for vx_mem_rr_arbiter against a transaction-level
// model: a priority pointer, per-requester read counts and a list of reads in flight.
module tb_vx_mem_rr_arbiter;
  localparam int N   = 4;
  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int TW  = 8;
  localparam int MP  = 4;
  localparam int BW  = DW / 8;
  localparam int TOW = TW + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_mem_rr_arbiter_if #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)) bus ();

  vx_mem_rr_arbiter #(
    .NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference state
  int               ptr_m;
  int               pend_m [N];
  bit               mv, mrw, mbusy;
  logic [BW-1:0]    mbe;
  logic [AW-1:0]    maddr;
  logic [DW-1:0]    mdata;
  logic [TOW-1:0]   mtag;
  logic [TOW-1:0]   outst [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.req_valid_in  = '0;
    bus.req_rw_in     = '0;
    bus.req_byteen_in = '0;
    bus.req_addr_in   = '0;
    bus.req_data_in   = '0;
    bus.req_tag_in    = '0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_rsp_tag   = '0;
    bus.rsp_ready_out = '1;
  endtask

  task automatic set_req(input int i, input bit rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    bus.req_valid_in[i]           = 1'b1;
    bus.req_rw_in[i]              = rw;
    bus.req_addr_in[i*AW +: AW]   = addr;
    bus.req_tag_in[i*TW +: TW]    = tag;
    bus.req_data_in[i*DW +: DW]   = $urandom;
    bus.req_byteen_in[i*BW +: BW] = BW'($urandom);
  endtask

  task automatic set_rsp(input logic [TOW-1:0] tag, input logic [N-1:0] rdy);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_tag   = tag;
    bus.mem_rsp_data  = $urandom;
    bus.rsp_ready_out = rdy;
  endtask

  task automatic rand_inputs();
    idle();
    for (int i = 0; i < N; i++)
      if ($urandom_range(0, 2) != 0) set_req(i, ($urandom_range(0, 3) == 0), AW'($urandom), TW'($urandom));
    bus.mem_req_ready = ($urandom_range(0, 3) != 0);
    if (outst.size() > 0 && $urandom_range(0, 1) == 1)
      set_rsp(outst[$urandom_range(0, outst.size() - 1)], N'($urandom));
    else
      bus.rsp_ready_out = N'($urandom);
  endtask

  // Check outputs for the inputs currently driven, then advance the model one clock.
  task automatic step();
    int win, ridx;
    bit en, rfire;
    logic [N-1:0] exp_rdy, exp_rv;
    logic [TOW-1:0] rtag;
    #1;
    en  = !mv || bus.mem_req_ready;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr_m + k) % N;
      if (win < 0 && bus.req_valid_in[j] && (bus.req_rw_in[j] || pend_m[j] < MP)) win = j;
    end
    exp_rdy = (en && win >= 0) ? N'(1 << win) : '0;
    chk("req_ready_in", 64'(bus.req_ready_in), 64'(exp_rdy));
    chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(mv));
    if (mv) begin
      chk("mem_req_rw", 64'(bus.mem_req_rw), 64'(mrw));
      chk("mem_req_byteen", 64'(bus.mem_req_byteen), 64'(mbe));
      chk("mem_req_addr", 64'(bus.mem_req_addr), 64'(maddr));
      chk("mem_req_data", 64'(bus.mem_req_data), 64'(mdata));
      chk("mem_req_tag", 64'(bus.mem_req_tag), 64'(mtag));
    end
    chk("busy", 64'(bus.busy), 64'(mbusy));
    rtag   = bus.mem_rsp_tag;
    ridx   = int'(rtag[TOW-1 -: 2]);
    exp_rv = bus.mem_rsp_valid ? N'(1 << ridx) : '0;
    chk("rsp_valid_out", 64'(bus.rsp_valid_out), 64'(exp_rv));
    chk("mem_rsp_ready", 64'(bus.mem_rsp_ready), 64'(bus.rsp_ready_out[ridx]));
    if (bus.mem_rsp_valid) begin
      chk("rsp_tag_out", 64'(bus.rsp_tag_out), 64'(rtag[TW-1:0]));
      chk("rsp_data_out", 64'(bus.rsp_data_out), 64'(bus.mem_rsp_data));
    end
    rfire = bus.mem_rsp_valid && bus.rsp_ready_out[ridx];
    @(posedge clk);
    if (reset) begin
      mv    = 1'b0;
      ptr_m = 0;
      for (int k = 0; k < N; k++) pend_m[k] = 0;
      outst.delete();
    end else begin
      if (rfire) begin
        for (int q = 0; q < outst.size(); q++)
          if (outst[q] == rtag) begin
            outst.delete(q);
            break;
          end
        if (pend_m[ridx] > 0) pend_m[ridx]--;
      end
      if (en) begin
        if (win >= 0) begin
          mv    = 1'b1;
          mrw   = bus.req_rw_in[win];
          mbe   = bus.req_byteen_in[win*BW +: BW];
          maddr = bus.req_addr_in[win*AW +: AW];
          mdata = bus.req_data_in[win*DW +: DW];
          mtag  = {2'(win), bus.req_tag_in[win*TW +: TW]};
          ptr_m = (win + 1) % N;
          if (!mrw) begin
            pend_m[win]++;
            outst.push_back(mtag);
          end
        end else begin
          mv = 1'b0;
        end
      end
    end
    mbusy = mv;
    for (int k = 0; k < N; k++) if (pend_m[k] != 0) mbusy = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int c = 0; c < 200; c++) begin
      if (outst.size() == 0 && !mv) break;
      idle();
      if (outst.size() > 0) set_rsp(outst[0], '1);
      step();
    end
    chk("drain_left", 64'(outst.size() + int'(mv)), 64'(0));
  endtask

  function automatic logic [TOW-1:0] first_tag_of(input int r);
    first_tag_of = '0;
    for (int q = outst.size() - 1; q >= 0; q--)
      if (int'(outst[q][TOW-1 -: 2]) == r) first_tag_of = outst[q];
  endfunction

  initial begin
    idle();
    mv = 1'b0; mrw = 1'b0; mbusy = 1'b0; ptr_m = 0;
    mbe = '0; maddr = '0; mdata = '0; mtag = '0;
    for (int k = 0; k < N; k++) pend_m[k] = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 64'(bus.mem_req_valid), 64'(0));
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_ptr", 64'(dut.ptr), 64'(0));
    reset = 1'b0;

    // All four read continuously: grants rotate 0,1,2,3,...
    for (int c = 0; c < 8; c++) begin
      idle();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'($urandom), TW'(c));
      step();
      chk("rr_valid", 64'(bus.mem_req_valid), 64'(1));
      chk("rr_order", 64'(bus.mem_req_tag[TOW-1 -: 2]), 64'(c % N));
    end
    drain();

    // Backpressure: staged request held for 5 cycles
    idle();
    bus.mem_req_ready = 1'b0;
    set_req(1, 1'b0, AW'('h100), 8'h5A);
    step();
    for (int c = 0; c < 5; c++) begin
      idle();
      bus.mem_req_ready = 1'b0;
      set_req(1, 1'b0, AW'($urandom), TW'($urandom));
      #1;
      chk("hold_ready", 64'(bus.req_ready_in), 64'(0));
      chk("hold_addr", 64'(bus.mem_req_addr), 64'('h100));
      chk("hold_tag", 64'(bus.mem_req_tag), 64'('h15A));
      step();
    end
    idle();
    #1;
    chk("hold_issue", 64'({bus.mem_req_valid, bus.mem_req_ready, bus.mem_req_tag}), 64'({2'b11, 10'h15A}));
    step();
    drain();

    // Throttling of requester 0 at MAX_PENDING reads
    for (int c = 0; c < MP; c++) begin
      idle();
      set_req(0, 1'b0, AW'($urandom), TW'(c));
      step();
    end
    idle(); set_req(0, 1'b0, AW'($urandom), 8'h10);
    #1; chk("thr_stall", 64'(bus.req_ready_in), 64'(0));
    step();
    idle(); set_req(0, 1'b1, AW'($urandom), 8'h11);
    #1; chk("thr_write", 64'(bus.req_ready_in), 64'(1));
    step();
    idle(); set_req(0, 1'b0, AW'($urandom), 8'h12); set_req(2, 1'b0, AW'($urandom), 8'h13);
    #1; chk("thr_other", 64'(bus.req_ready_in), 64'(4));
    step();
    idle(); set_req(0, 1'b0, AW'($urandom), 8'h14); set_rsp(first_tag_of(0), '1);
    #1; chk("thr_rsp_cycle", 64'(bus.req_ready_in), 64'(0));
    step();
    idle(); set_req(0, 1'b0, AW'($urandom), 8'h15);
    #1; chk("thr_release", 64'(bus.req_ready_in), 64'(1));
    step();
    drain();

    // Response routing with the target requester not ready
    idle(); set_req(3, 1'b0, AW'($urandom), 8'h7F);
    step();
    idle(); set_rsp({2'd3, 8'h7F}, 4'b0111);
    #1;
    chk("route_valid", 64'(bus.rsp_valid_out), 64'(4'b1000));
    chk("route_blocked", 64'(bus.mem_rsp_ready), 64'(0));
    step();
    idle(); set_rsp({2'd3, 8'h7F}, 4'b1111);
    #1; chk("route_accept", 64'(bus.mem_rsp_ready), 64'(1));
    step();
    chk("pend3_dec", 64'(dut.pending[3]), 64'(0));

    // Read fire and response for the same requester in one cycle
    for (int c = 0; c < 3; c++) begin
      idle(); set_req(1, 1'b0, AW'($urandom), TW'(8'h20 + c));
      step();
    end
    chk("pend1_pre", 64'(dut.pending[1]), 64'(3));
    idle(); set_req(1, 1'b0, AW'($urandom), 8'h30); set_rsp(first_tag_of(1), '1);
    step();
    chk("pend1_same", 64'(dut.pending[1]), 64'(3));
    drain();
    chk("busy_drained", 64'(bus.busy), 64'(0));

    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      step();
    end
    drain();

    // Reset while a request is staged and reads are outstanding
    idle(); set_req(0, 1'b0, AW'($urandom), 8'h40); step();
    idle(); set_req(1, 1'b0, AW'($urandom), 8'h41); step();
    idle(); set_req(2, 1'b0, AW'($urandom), 8'h42); bus.mem_req_ready = 1'b0; step();
    chk("pre_rst_valid", 64'(bus.mem_req_valid), 64'(1));
    reset = 1'b1;
    idle(); bus.mem_req_ready = 1'b0;
    step();
    reset = 1'b0;
    idle();
    #1;
    chk("mid_rst_valid", 64'(bus.mem_req_valid), 64'(0));
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_ptr", 64'(dut.ptr), 64'(0));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
